// File: rtl/image_line_feeder_if.sv
// image_line_feeder_if
//   Bundles the feeder's control, frame-RAM and pixel-stream signals.
//   Parameter: ADDR_W - frame RAM address width.
//   Signals:
//     i_start      start pulse into the feeder
//     o_busy       feeder is working on a frame
//     o_done       one-cycle end-of-frame pulse
//     o_mem_rd     frame RAM read enable
//     o_mem_addr   frame RAM address
//     i_mem_data   frame RAM read data, one cycle after o_mem_rd
//     o_data_valid stream valid toward the blur IP
//     o_data       stream pixel toward the blur IP
//     i_data_ready blur IP ready
//     i_intr       blur IP line-consumed interrupt (level)
//   Modports: master = feeder side, slave = environment side.
interface image_line_feeder_if #(
  parameter int ADDR_W = 18
) ();
  logic              i_start;
  logic              o_busy;
  logic              o_done;
  logic              o_mem_rd;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        i_mem_data;
  logic              o_data_valid;
  logic [7:0]        o_data;
  logic              i_data_ready;
  logic              i_intr;

  modport master (
    input  i_start,
    output o_busy, o_done,
    output o_mem_rd, o_mem_addr,
    input  i_mem_data,
    output o_data_valid, o_data,
    input  i_data_ready, i_intr
  );

  modport slave (
    output i_start,
    input  o_busy, o_done,
    input  o_mem_rd, o_mem_addr,
    output i_mem_data,
    input  o_data_valid, o_data,
    output i_data_ready, i_intr
  );
endinterface

// File: rtl/image_line_feeder.sv
// image_line_feeder
//   Pixel source for the blur pipeline. Streams PRIME_LINES lines of an
//   8-bit frame from a synchronous frame RAM, then one more line per rising
//   edge of the pipeline's line-done interrupt, then PAD_LINES padding lines.
//   Ports:
//     axi_clk    sole clock, rising edge
//     axi_reset  asynchronous, active-high reset
//     bus        image_line_feeder_if.master (start/busy/done, RAM, stream, intr)
//   Build option: EDGE_REPLICATE_EN - padding lines re-read the last image
//   line instead of emitting zeros.
//
//   state     | meaning
//   IDLE      | waiting for i_start
//   PRIME     | streaming the first PRIME_LINES lines back to back
//   WAIT_INTR | line boundary, waiting for a latched interrupt edge
//   LINE      | streaming one image line
//   PAD       | streaming one padding line
//   DONE      | one-cycle o_done pulse
module image_line_feeder #(
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512,
  parameter int PRIME_LINES = 4,
  parameter int PAD_LINES   = 2,
  parameter int ADDR_W      = 18
) (
  input logic                 axi_clk,
  input logic                 axi_reset,
  image_line_feeder_if.master bus
);
  localparam int PIX_W   = $clog2(IMG_WIDTH);
  localparam int LINE_W  = $clog2(IMG_HEIGHT + 1);
  localparam int PAD_W   = $clog2(PAD_LINES + 1);
  localparam int FETCH_W = $clog2(PRIME_LINES * IMG_WIDTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] EDGE_BASE = ADDR_W'((IMG_HEIGHT - 1) * IMG_WIDTH);

`ifdef EDGE_REPLICATE_EN
  localparam bit PAD_READS = 1'b1;
`else
  localparam bit PAD_READS = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, PRIME, WAIT_INTR, LINE, PAD, DONE} stateT;

  stateT             state, stateNext;
  logic [PIX_W-1:0]  pixCnt;
  logic [LINE_W-1:0] linesSent;
  logic [PAD_W-1:0]  padSent;
  logic [FETCH_W-1:0] fetchLeft;
  logic [ADDR_W-1:0] addrReg;
  logic              fetchD, zeroD;
  logic [7:0]        fifoMem [2];
  logic              wrPtr, rdPtr;
  logic [1:0]        fifoCnt, occAfter;
  logic              intrPrev, intrPending, pendClr;
  logic              streaming, dataValid, beat, pixLast, fetch, padZero;
  logic              intrEdge, busyState;

  assign streaming = (state == PRIME) || (state == LINE) || (state == PAD);
  assign dataValid = (fifoCnt != 2'd0);
  assign beat      = dataValid && bus.i_data_ready;
  assign pixLast   = (pixCnt == PIX_W'(IMG_WIDTH - 1));
  // Occupancy once this cycle's pop and the in-flight read have settled;
  // counting the pop keeps 1 pixel/cycle with ready held high.
  assign occAfter  = fifoCnt + {1'b0, fetchD} - {1'b0, beat};
  assign fetch     = streaming && (fetchLeft != '0) && (occAfter < 2'd2);
  // Zero padding still runs through the pipeline as a read slot, just
  // without touching the RAM, so handshake timing matches image lines.
  assign padZero   = (state == PAD) && !PAD_READS;
  assign intrEdge  = bus.i_intr && !intrPrev;
  assign busyState = (state != IDLE) && (state != DONE);

  assign bus.o_mem_rd     = fetch && !padZero;
  assign bus.o_mem_addr   = addrReg;
  assign bus.o_data_valid = dataValid;
  assign bus.o_data       = fifoMem[rdPtr];
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_done       = (state == DONE);

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) state <= IDLE;
    else           state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    pendClr   = 1'b0;
    case (state)
      IDLE: if (bus.i_start) stateNext = PRIME;
      PRIME:
        if (beat && pixLast && linesSent == LINE_W'(PRIME_LINES - 1))
          stateNext = WAIT_INTR;
      WAIT_INTR:
        if (intrPending) begin
          pendClr = 1'b1;
          if (linesSent < LINE_W'(IMG_HEIGHT))   stateNext = LINE;
          else if (padSent < PAD_W'(PAD_LINES)) stateNext = PAD;
          else                                   stateNext = DONE;
        end
      LINE: if (beat && pixLast) stateNext = WAIT_INTR;
      PAD:
        if (beat && pixLast)
          stateNext = (padSent == PAD_W'(PAD_LINES - 1)) ? DONE : WAIT_INTR;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      pixCnt    <= '0;
      linesSent <= '0;
      padSent   <= '0;
      fetchLeft <= '0;
      addrReg   <= '0;
    end else begin
      if (state == IDLE && bus.i_start) begin
        pixCnt    <= '0;
        linesSent <= '0;
        padSent   <= '0;
        addrReg   <= '0;
      end else begin
        if (fetch) fetchLeft <= fetchLeft - 1'b1;
        // Address saturates at the last pixel so it never leaves the frame.
        if (bus.o_mem_rd && addrReg != LAST_ADDR) addrReg <= addrReg + 1'b1;
        if (beat) begin
          pixCnt <= pixLast ? '0 : pixCnt + 1'b1;
          if (pixLast) begin
            if (state == PAD) padSent   <= padSent + 1'b1;
            else              linesSent <= linesSent + 1'b1;
          end
        end
      end
      if (state != stateNext) begin
        case (stateNext)
          PRIME: fetchLeft <= FETCH_W'(PRIME_LINES * IMG_WIDTH);
          LINE:  fetchLeft <= FETCH_W'(IMG_WIDTH);
          PAD: begin
            fetchLeft <= FETCH_W'(IMG_WIDTH);
            if (PAD_READS) addrReg <= EDGE_BASE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      fifoMem[0] <= 8'd0;
      fifoMem[1] <= 8'd0;
      wrPtr      <= 1'b0;
      rdPtr      <= 1'b0;
      fifoCnt    <= 2'd0;
      fetchD     <= 1'b0;
      zeroD      <= 1'b0;
    end else begin
      if (fetchD) begin
        fifoMem[wrPtr] <= zeroD ? 8'd0 : bus.i_mem_data;
        wrPtr          <= ~wrPtr;
      end
      if (beat) rdPtr <= ~rdPtr;
      fifoCnt <= fifoCnt + {1'b0, fetchD} - {1'b0, beat};
      fetchD  <= fetch;
      zeroD   <= fetch && padZero;
    end
  end

  // A new edge wins over the WAIT_INTR clear so back-to-back edges are kept.
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      intrPrev    <= 1'b0;
      intrPending <= 1'b0;
    end else begin
      intrPrev <= bus.i_intr;
      if (intrEdge && busyState) intrPending <= 1'b1;
      else if (pendClr)          intrPending <= 1'b0;
    end
  end
endmodule

// File: tb/tb_image_line_feeder.sv
// tb_image_line_feeder
//   Directed bench for image_line_feeder with an 8x6 frame, RAM[a] = a.
//   Define EDGE_REPLICATE_EN to expect replicated padding lines.
module tb_image_line_feeder;
  localparam int W = 8, H = 6, PL = 4, PD = 2, AW = 6;
  localparam int NBEAT = (H + PD) * W;
  localparam int BUDGET = 2000;

  logic axi_clk = 1'b0;
  logic axi_reset;
  logic [7:0] ramQ = 8'd0;

  image_line_feeder_if #(.ADDR_W(AW)) io ();

  image_line_feeder #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PRIME_LINES(PL), .PAD_LINES(PD), .ADDR_W(AW)
  ) dut (
    .axi_clk  (axi_clk),
    .axi_reset(axi_reset),
    .bus      (io)
  );

  always #5 axi_clk = ~axi_clk;

  always @(posedge axi_clk) if (io.o_mem_rd) ramQ <= 8'(io.o_mem_addr);
  assign io.i_mem_data = ramQ;

  int nChecks = 0, nFail = 0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, away from the active edge.
  bit monOn = 1'b0;
  int beats, doneCnt, maxAddr, stallErr, idleBeats;
  logic [7:0] beatLog[$];
  logic prevStall = 1'b0;
  logic [7:0] prevData = 8'd0;

  task automatic clearMon();
    beats = 0; doneCnt = 0; maxAddr = 0; stallErr = 0; idleBeats = 0;
    beatLog.delete();
  endtask

  always @(negedge axi_clk) begin
    if (monOn) begin
      if (prevStall && (!io.o_data_valid || io.o_data != prevData)) stallErr++;
      if (io.o_data_valid && io.i_data_ready) begin
        beatLog.push_back(io.o_data);
        beats++;
        if (!io.o_busy) idleBeats++;
      end
      if (io.o_done) doneCnt++;
      if (io.o_mem_rd && int'(io.o_mem_addr) > maxAddr) maxAddr = int'(io.o_mem_addr);
      prevStall = io.o_data_valid && !io.i_data_ready;
      prevData  = io.o_data;
    end else begin
      prevStall = 1'b0;
    end
  end

  function automatic int expPix(input int i);
    if (i < H * W) return i;
`ifdef EDGE_REPLICATE_EN
    return (H - 1) * W + (i % W);
`else
    return 0;
`endif
  endfunction

  function automatic int logErrors(input int n);
    int e = 0;
    for (int i = 0; i < n && i < beatLog.size(); i++)
      if (int'(beatLog[i]) != expPix(i)) e++;
    return e;
  endfunction

  // readyMode: 0 = ready held high, 1 = toggled each cycle.
  // intrMode: 0 = pulse 20 cycles after each line, 1 = early + mid-line pulses.
  task automatic runFrame(input int readyMode, input int intrMode, input int startAt,
                          input int abortAt, output bit timedOut);
    int trig[4];
    int dly[4];
    int tIdx = 0, timer = 0, hold = 0, tail = 0;
    bit doneSeen = 1'b0, startFired = 1'b0;
    if (intrMode == 0) begin
      trig = '{PL * W, (PL + 1) * W, H * W, (H + 1) * W};
      dly  = '{20, 20, 20, 20};
    end else begin
      trig = '{2, PL * W + 4, H * W, (H + 1) * W};
      dly  = '{0, 0, 20, 20};
    end
    clearMon();
    monOn = 1'b1;
    io.i_data_ready = 1'b1;
    @(posedge axi_clk); #1;
    io.i_start = 1'b1;
    @(posedge axi_clk); #1;
    io.i_start = 1'b0;
    timedOut = 1'b1;
    for (int n = 0; n < BUDGET; n++) begin
      io.i_data_ready = (readyMode == 0) ? 1'b1 : ((n % 2) == 0);
      if (tIdx < 4 && beats >= trig[tIdx]) begin
        timer = dly[tIdx] + 1;
        tIdx++;
      end
      if (timer > 0) begin
        timer--;
        if (timer == 0) hold = 2;
      end
      io.i_intr = (hold > 0);
      if (hold > 0) hold--;
      io.i_start = 1'b0;
      if (startAt > 0 && !startFired && beats >= startAt) begin
        io.i_start = 1'b1;
        startFired = 1'b1;
      end
      if (abortAt > 0 && beats >= abortAt) begin
        #2;
        axi_reset = 1'b1;
        timedOut = 1'b0;
        break;
      end
      if (doneSeen) tail++;
      if (doneCnt > 0) doneSeen = 1'b1;
      if (tail >= 30) begin
        timedOut = 1'b0;
        break;
      end
      @(posedge axi_clk); #1;
    end
    io.i_intr = 1'b0;
    io.i_start = 1'b0;
  endtask

  typedef struct {
    string name;
    int readyMode;
    int intrMode;
    int startAt;
    int expBeats;
    int expDone;
    int expMaxAddr;
  } frameVecT;

  frameVecT vecs[4];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit tmo;
    vecs[0] = '{"ready_high",  0, 0, 0,  NBEAT, 1, H * W - 1};
    vecs[1] = '{"ready_toggle",1, 0, 0,  NBEAT, 1, H * W - 1};
    vecs[2] = '{"early_intr",  0, 1, 0,  NBEAT, 1, H * W - 1};
    vecs[3] = '{"start_in_line",0, 0, PL * W + 3, NBEAT, 1, H * W - 1};

    axi_reset = 1'b1;
    io.i_start = 1'b0;
    io.i_data_ready = 1'b1;
    io.i_intr = 1'b0;
    @(negedge axi_clk);
    @(negedge axi_clk);
    check("rst_busy",  int'(io.o_busy), 0);
    check("rst_done",  int'(io.o_done), 0);
    check("rst_rd",    int'(io.o_mem_rd), 0);
    check("rst_addr",  int'(io.o_mem_addr), 0);
    check("rst_valid", int'(io.o_data_valid), 0);
    check("rst_data",  int'(io.o_data), 0);
    @(posedge axi_clk); #1;
    axi_reset = 1'b0;

    // Interrupt edges while idle must not start anything or be remembered.
    clearMon();
    monOn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge axi_clk); #1; io.i_intr = 1'b1;
      @(posedge axi_clk); #1; io.i_intr = 1'b0;
    end
    @(negedge axi_clk);
    check("idle_intr_busy",  int'(io.o_busy), 0);
    check("idle_intr_valid", int'(io.o_data_valid), 0);

    // First-beat latency: rd at entry, valid two edges after entry.
    @(posedge axi_clk); #1; io.i_start = 1'b1;
    @(posedge axi_clk); #1; io.i_start = 1'b0;
    @(negedge axi_clk);
    check("lat_rd0",    int'(io.o_mem_rd), 1);
    check("lat_addr0",  int'(io.o_mem_addr), 0);
    check("lat_valid0", int'(io.o_data_valid), 0);
    check("lat_busy",   int'(io.o_busy), 1);
    @(negedge axi_clk);
    check("lat_valid1", int'(io.o_data_valid), 0);
    @(negedge axi_clk);
    check("lat_valid2", int'(io.o_data_valid), 1);
    check("lat_data2",  int'(io.o_data), 0);
    // Without a fresh interrupt the feeder must stall after the prime lines.
    repeat (60) @(negedge axi_clk);
    check("prime_wait_beats", beats, PL * W);
    check("prime_wait_valid", int'(io.o_data_valid), 0);
    check("prime_wait_busy",  int'(io.o_busy), 1);
    check("prime_wait_data",  logErrors(beats), 0);
    @(posedge axi_clk); #1; axi_reset = 1'b1;
    @(posedge axi_clk); #1; axi_reset = 1'b0;

    // Reset in the middle of a line aborts at once.
    runFrame(0, 0, 0, 37, tmo);
    check("abort_reached", int'(tmo), 0);
    #1;
    check("abort_valid", int'(io.o_data_valid), 0);
    check("abort_rd",    int'(io.o_mem_rd), 0);
    check("abort_busy",  int'(io.o_busy), 0);
    check("abort_addr",  int'(io.o_mem_addr), 0);
    check("abort_data",  int'(io.o_data), 0);
    check("abort_done",  int'(io.o_done), 0);
    check("abort_beats", beats, 37);
    check("abort_prefix", logErrors(beats), 0);
    repeat (3) @(negedge axi_clk);
    check("abort_no_beats", beats, 37);
    @(posedge axi_clk); #1; axi_reset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      runFrame(vecs[v].readyMode, vecs[v].intrMode, vecs[v].startAt, 0, tmo);
      check({vecs[v].name, "_timeout"},   int'(tmo), 0);
      check({vecs[v].name, "_beats"},     beats, vecs[v].expBeats);
      check({vecs[v].name, "_data_err"},  logErrors(beats), 0);
      check({vecs[v].name, "_done"},      doneCnt, vecs[v].expDone);
      check({vecs[v].name, "_busy_end"},  int'(io.o_busy), 0);
      check({vecs[v].name, "_max_addr"},  maxAddr, vecs[v].expMaxAddr);
      check({vecs[v].name, "_stall"},     stallErr, 0);
      check({vecs[v].name, "_idle_beat"}, idleBeats, 0);
    end

    monOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/image_line_feeder.md
Name: image_line_feeder

Overview:
- Hardware pixel source for the imageProcessTop blur pipeline; the transmitting end of its slave stream and interrupt protocol.
- Reads an 8-bit grayscale frame from a synchronous frame RAM.
- Streams PRIME_LINES lines up front, then one further line per rising edge of the pipeline's line-done interrupt, then PAD_LINES padding lines to flush the line buffers.
- Sits between frame memory and the blur IP's i_data/i_data_valid/o_data_ready/o_intr pins.

Parameters:
- IMG_WIDTH, 512, pixels per line
- IMG_HEIGHT, 512, lines per frame
- PRIME_LINES, 4, lines sent before the first interrupt is honoured
- PAD_LINES, 2, padding lines appended after the last image line
- ADDR_W, 18, frame RAM address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT

Ports:
- axi_clk  in  1  sole clock, all logic on rising edge
- axi_reset  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle pulse, begins a frame when idle
- o_busy  out  1  high from accepted start until done
- o_done  out  1  one-cycle pulse after last padding pixel accepted
- o_mem_rd  out  1  frame RAM read enable
- o_mem_addr  out  ADDR_W  frame RAM address, row-major from 0
- i_mem_data  in  8  read data, valid exactly 1 cycle after o_mem_rd
- o_data_valid  out  1  stream valid to IP i_data_valid
- o_data  out  8  stream pixel to IP i_data
- i_data_ready  in  1  IP o_data_ready; a beat transfers when valid && ready
- i_intr  in  1  IP o_intr, line-consumed interrupt, level signal, edge-detected here

Behaviour:
- Clocking and reset: one clock, axi_clk. Reset axi_reset is asynchronous and active-high.
- Reset state: o_busy=0, o_done=0, o_mem_rd=0, o_mem_addr=0, o_data_valid=0, o_data=0. FSM in IDLE; all counters, intr_pending and the skid FIFO cleared. Reset asserted mid-frame aborts immediately with no further beats.
- FSM states: IDLE, PRIME, WAIT_INTR, LINE, PAD, DONE.
- IDLE -> PRIME on i_start. i_start in any other state is ignored.
- PRIME: fetch and send PRIME_LINES*IMG_WIDTH pixels, addresses 0 upward. When the last beat is accepted, lines_sent=PRIME_LINES and FSM -> WAIT_INTR.
- WAIT_INTR, evaluated when intr_pending=1 (pending is cleared on the same cycle):
  - lines_sent < IMG_HEIGHT -> LINE
  - else pad_sent < PAD_LINES -> PAD
  - else -> DONE
- LINE: send IMG_WIDTH pixels at the next sequential addresses, then lines_sent++ and -> WAIT_INTR.
- PAD: send IMG_WIDTH beats with o_data=0 and no RAM reads, then pad_sent++ and -> WAIT_INTR. After the final pad line -> DONE directly; no interrupt is awaited.
- DONE: o_done=1 for one cycle, then -> IDLE. o_busy falls on that same transition.
- Interrupt handling:
  - intr_pending is set on a detected 0->1 of i_intr, using a registered previous value.
  - Edges in any busy state (including mid-line) are latched, so none are lost. A second edge while pending is already set is absorbed (no count).
  - Edges in IDLE or DONE are ignored.
  - Simultaneous set and clear: set wins.
- Read pipeline:
  - 2-entry skid FIFO feeds o_data/o_data_valid.
  - A RAM read is issued only when FIFO occupancy + in-flight reads < 2 and the current line has pixels left to fetch.
  - Read data is written to the FIFO the cycle after o_mem_rd.
  - o_data and o_data_valid must stay stable while valid && !ready.
  - With i_data_ready held high, throughput is 1 pixel/cycle after the first read. First o_data_valid appears 2 cycles after the PRIME entry edge.
- Counters:
  - Pixel-in-line counter is clog2(IMG_WIDTH) bits and wraps to 0 at IMG_WIDTH-1 on accept.
  - lines_sent is clog2(IMG_HEIGHT+1) bits; pad_sent is clog2(PAD_LINES+1) bits.
  - o_mem_addr increments by 1 per read and never exceeds IMG_WIDTH*IMG_HEIGHT-1.
- No beat is ever emitted in IDLE, WAIT_INTR or DONE. The FIFO must be empty on each line boundary before WAIT_INTR is entered.

Optional Feature:
- Macro: EDGE_REPLICATE_EN.
- Defined: PAD lines re-read the last image line, addresses (IMG_HEIGHT-1)*IMG_WIDTH through IMG_HEIGHT*IMG_WIDTH-1, for every pad line, through the same read pipeline and handshake rules. This gives replicate-border filtering.
- Not defined: PAD beats are constant 0 and no RAM reads occur in PAD.

Test Plan:
- W=8,H=6,PRIME=4,PAD=2, RAM[a]=a, ready=1, i_start, then an intr pulse 20 cycles after each line ends -> 32 beats 0..31, then lines 32..39 and 40..47, then 16 zero beats. Exactly 64 beats total, o_done one pulse, o_busy low after.
- Same setup, i_data_ready toggled 1/0 each cycle -> identical 64-beat sequence, o_data stable during every stall, o_mem_addr never above 47.
- Intr pulse arriving during the 3rd pixel of PRIME plus a second pulse mid-LINE -> each edge latched once. Next line starts right after the current line completes; no line is skipped or duplicated.
- Reset asserted at beat 37, then released and i_start given -> outputs return to reset values asynchronously, and the frame restarts at address 0 with pixel 0.
- i_start pulsed during LINE, and intr pulses while IDLE -> no effect, no extra beats.
- EDGE_REPLICATE_EN defined, same stimulus as the first test -> both pad lines carry 40..47.
